// File: rtl/mem_unit_if.sv
// Handshake and data bundle between the control unit (master) and mem_unit (slave).
// Carries the MAR address, MBR write data, request strobes and completion status.
interface mem_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mar_data;
  logic [DATA_W-1:0] mbr_wdata;
  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              req_err;
  logic              par_err;

  modport master (
    output mar_data, mbr_wdata, rd_req, wr_req,
    input  mem_rdata, busy, done, req_err, par_err
  );

  modport slave (
    input  mar_data, mbr_wdata, rd_req, wr_req,
    output mem_rdata, busy, done, req_err, par_err
  );
endinterface

// File: rtl/mem_unit.sv
// Main-memory stage: multi-cycle read into / write from the MBR at the MAR address.
// Optional macro MEM_PARITY_EN stores an even-parity bit per word and drives par_err.
module mem_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_unit_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_op_q;
  logic              busy_q;
  logic              done_q;
  logic              req_err_q;
  logic [3:0]        cnt_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              req_d;
  logic              fire_d;
  logic              mem_we_d;
  logic [MEM_W-1:0]  wword_d;
  logic [MEM_W-1:0]  rword_d;

  always_comb begin
    req_d    = bus.rd_req | bus.wr_req;
    fire_d   = (state_q == ACCESS) && (cnt_q == 4'd0);
    mem_we_d = fire_d && wr_op_q;
    rword_d  = mem_q[addr_q];
`ifdef MEM_PARITY_EN
    wword_d  = {^wdata_q, wdata_q};
`else
    wword_d  = wdata_q;
`endif
  end

  // Array has no reset so contents survive rst; an aborted access never reaches fire_d.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[addr_q] <= wword_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_op_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_err_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (req_d) begin
            addr_q  <= bus.mar_data;
            wdata_q <= bus.mbr_wdata;
            wr_op_q <= bus.wr_req;
            cnt_q   <= 4'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (req_d) begin
            req_err_q <= 1'b1;
          end
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_op_q) begin
              rdata_q <= rword_d[DATA_W-1:0];
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic par_err_q;

  // Stored word carries even parity, so any odd XOR across it flags corruption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (fire_d && !wr_op_q) begin
      par_err_q <= ^rword_d;
    end
  end

  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.mem_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.req_err   = req_err_q;
endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: WAIT_CYCLES=2 instance driven through a scoreboard,
// plus a WAIT_CYCLES=0 instance for the minimum-latency case.
module tb_mem_unit;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  mem_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_v;
  int            nb;
  bit            ok;

  // Drive one request for a single edge and push the mem_rdata expected at its done.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.rd_req    = rd;
    bus.wr_req    = wr;
    bus.mar_data  = a;
    bus.mbr_wdata = d;
    if (wr) model[a] = d;
    else if (rd) last_rd = model[a];
    sb.push_back(last_rd);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic wait_done(output int busy_n, output bit got);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_rdata, bus.busy, bus.done, bus.req_err, bus.par_err} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_outputs: got %h want 00000",
               {bus.mem_rdata, bus.busy, bus.done, bus.req_err, bus.par_err});
    end
    n_cmp++;
    if ({bus0.mem_rdata, bus0.busy, bus0.done, bus0.req_err, bus0.par_err} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_outputs_w0: got %h want 00000",
               {bus0.mem_rdata, bus0.busy, bus0.done, bus0.req_err, bus0.par_err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    issue(1'b0, 1'b1, 8'h10, 16'hBEEF);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || nb != 3) begin
      n_mis++;
      $display("[TB] FAIL write_latency: done=%0b busy_cycles=%0d want done=1 busy_cycles=3", ok, nb);
    end
    n_cmp++;
    if (bus.mem_rdata !== exp_v) begin
      n_mis++;
      $display("[TB] FAIL write_keeps_rdata: got %h want %h", bus.mem_rdata, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL done_one_cycle: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_read();
    issue(1'b1, 1'b0, 8'h10, 16'h0000);
    bus.mar_data  = 8'h20;
    bus.mbr_wdata = 16'h7777;
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || nb != 3) begin
      n_mis++;
      $display("[TB] FAIL read_latency: done=%0b busy_cycles=%0d want done=1 busy_cycles=3", ok, nb);
    end
    n_cmp++;
    if (bus.mem_rdata !== exp_v || bus.par_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL read_data: got %h par=%b want %h par=0", bus.mem_rdata, bus.par_err, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_both();
    issue(1'b1, 1'b1, 8'hFF, 16'h1234);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v || bus.req_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL both_req_write_wins: done=%0b rdata=%h req_err=%b want 1 %h 0",
               ok, bus.mem_rdata, bus.req_err, exp_v);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 8'hFF, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v) begin
      n_mis++;
      $display("[TB] FAIL read_ff: done=%0b got %h want %h", ok, bus.mem_rdata, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_wait0();
    bus0.wr_req    = 1'b1;
    bus0.mar_data  = 8'h42;
    bus0.mbr_wdata = 16'h5555;
    @(negedge clk);
    bus0.wr_req = 1'b0;
    n_cmp++;
    if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL w0_access: busy=%b done=%b want 1 0", bus0.busy, bus0.done);
    end
    @(negedge clk);
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.mem_rdata !== 16'h0000) begin
      n_mis++;
      $display("[TB] FAIL w0_write_done: done=%b busy=%b rdata=%h want 1 0 0000",
               bus0.done, bus0.busy, bus0.mem_rdata);
    end
    bus0.rd_req   = 1'b1;
    bus0.mar_data = 8'h42;
    @(negedge clk);
    bus0.rd_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.mem_rdata !== 16'h5555) begin
      n_mis++;
      $display("[TB] FAIL w0_read_in_done: done=%b rdata=%h want 1 5555", bus0.done, bus0.mem_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_c;
    issue(1'b1, 1'b0, 8'h10, 16'h0000);
    wait_done(nb, ok);
    first_c = cyc;
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v) begin
      n_mis++;
      $display("[TB] FAIL b2b_first: done=%0b got %h want %h", ok, bus.mem_rdata, exp_v);
    end
    issue(1'b1, 1'b0, 8'hFF, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || (cyc - first_c) != 4) begin
      n_mis++;
      $display("[TB] FAIL b2b_spacing: done=%0b cycles=%0d want 4", ok, cyc - first_c);
    end
    n_cmp++;
    if (bus.mem_rdata !== exp_v || bus.req_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL b2b_second: got %h req_err=%b want %h 0", bus.mem_rdata, bus.req_err, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_req_err();
    issue(1'b0, 1'b1, 8'h30, 16'hA5A5);
    wait_done(nb, ok);
    void'(sb.pop_front());
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h30, 16'h0000);
    bus.wr_req    = 1'b1;
    bus.mar_data  = 8'h30;
    bus.mbr_wdata = 16'hDEAD;
    @(negedge clk);
    bus.wr_req = 1'b0;
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v || bus.req_err !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL req_err_set: done=%0b rdata=%h req_err=%b want 1 %h 1",
               ok, bus.mem_rdata, bus.req_err, exp_v);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h30, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v || bus.req_err !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL req_err_sticky: done=%0b rdata=%h req_err=%b want 1 %h 1",
               ok, bus.mem_rdata, bus.req_err, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    issue(1'b0, 1'b1, 8'h05, 16'h0001);
    wait_done(nb, ok);
    void'(sb.pop_front());
    @(negedge clk);
    bus.wr_req    = 1'b1;
    bus.mar_data  = 8'h05;
    bus.mbr_wdata = 16'hFFFF;
    @(negedge clk);
    bus.wr_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_rdata, bus.busy, bus.done, bus.req_err, bus.par_err} !== 20'h0) begin
      n_mis++;
      $display("[TB] FAIL async_reset: got %h want 00000",
               {bus.mem_rdata, bus.busy, bus.done, bus.req_err, bus.par_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    sb.delete();
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done !== 1'b0) done_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_mis++;
      $display("[TB] FAIL abort_no_done: done cycles=%0d want 0", done_seen);
    end
    issue(1'b1, 1'b0, 8'h05, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v) begin
      n_mis++;
      $display("[TB] FAIL abort_no_write: done=%0b got %h want %h", ok, bus.mem_rdata, exp_v);
    end
    @(negedge clk);
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    issue(1'b0, 1'b1, 8'h77, 16'h0F0F);
    wait_done(nb, ok);
    void'(sb.pop_front());
    @(negedge clk);
    dut.mem_q[8'h77][0] = ~dut.mem_q[8'h77][0];
    model[8'h77] = 16'h0F0E;
    issue(1'b1, 1'b0, 8'h77, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v || bus.par_err !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL parity_detect: rdata=%h par=%b want %h 1", bus.mem_rdata, bus.par_err, exp_v);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 8'h10, 16'h0000);
    wait_done(nb, ok);
    exp_v = sb.pop_front();
    n_cmp++;
    if (!ok || bus.mem_rdata !== exp_v || bus.par_err !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL parity_clear: rdata=%h par=%b want %h 0", bus.mem_rdata, bus.par_err, exp_v);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.rd_req     = 1'b0;
    bus.wr_req     = 1'b0;
    bus.mar_data   = '0;
    bus.mbr_wdata  = '0;
    bus0.rd_req    = 1'b0;
    bus0.wr_req    = 1'b0;
    bus0.mar_data  = '0;
    bus0.mbr_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_wait0();
    test_back_to_back();
    test_req_err();
    test_reset_abort();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Main-memory stage directly downstream of the memory address register.
- Consumes the 8-bit address held by the MAR and performs a read into, or a write from, the memory buffer register.
- Access timing is multi-cycle and configurable; handshaking uses request/busy/done.
- The control unit issues requests and stalls on busy until done.

Parameters:
- DATA_W, 16, word width of memory and MBR data paths
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- WAIT_CYCLES, 2, extra wait states per access (0..15); access occupies WAIT_CYCLES+1 cycles in ACCESS state

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mar_data  input  ADDR_W  address from MAR
- mbr_wdata  input  DATA_W  write data from MBR
- rd_req  input  1  read request, sampled on clock edge
- wr_req  input  1  write request, sampled on clock edge
- mem_rdata  output  DATA_W  read data to MBR, held until next completed read
- busy  output  1  access in progress, requests ignored
- done  output  1  one-cycle completion pulse
- req_err  output  1  sticky: request dropped while busy
- par_err  output  1  parity error on last read (feature-dependent)

Behaviour:
- Reset (async, rst=1): state=IDLE, mem_rdata=0, busy=0, done=0, req_err=0, par_err=0, wait counter=0. Memory array contents are not cleared.
- Reset mid-access aborts the access with no array write and no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE or DONE, with rd_req|wr_req sampled high at edge E0:
  - latch mar_data into addr_q, mbr_wdata into wdata_q, and op (write if wr_req else read);
  - load counter with WAIT_CYCLES;
  - go to ACCESS.
- ACCESS: busy=1. Each edge, if counter!=0, decrement. At the edge where counter==0:
  - perform the access (write: mem[addr_q]<=wdata_q; read: mem_rdata<=mem[addr_q]);
  - go to DONE.
- DONE: done=1, busy=0, for exactly one cycle. A new request sampled here is accepted as in IDLE; otherwise go to IDLE.
- Latency: request at E0 gives done high in the cycle after edge E0+WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Simultaneous rd_req and wr_req: write wins and the read is discarded. No error is flagged.
- rd_req or wr_req high while in ACCESS: ignored, and req_err set. req_err clears only on reset.
- Address and write data are captured at acceptance. Later changes to MAR/MBR do not affect an in-flight access.
- mem_rdata changes only at read completion; writes leave it unchanged.
- Read-after-write to the same address returns the newly written word.
- Address wrap: none needed; all 2**ADDR_W addresses are valid, including 8'hFF.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - array stores DATA_W+1 bits per word, the extra bit being the even parity of the data, computed at write;
  - on read completion, stored parity is recomputed and compared; par_err is updated (1 on mismatch, 0 on match) in the same edge as mem_rdata;
  - par_err holds until the next read completion or reset.
- Undefined: no parity storage; par_err tied to 0.

Test Plan:
- Reset, then WAIT_CYCLES=2: wr_req with mar_data=8'h10, mbr_wdata=16'hBEEF -> busy for 3 cycles, done pulse in cycle 4, mem_rdata stays 0.
- Read 8'h10 after that write -> done after 3 busy cycles, mem_rdata=16'hBEEF; changing mar_data to 8'h20 during ACCESS has no effect.
- rd_req and wr_req together at 8'hFF with data 16'h1234, then read 8'hFF -> 16'h1234 returned; mem_rdata unchanged by the combined request.
- wr_req pulsed during ACCESS of a prior read -> req_err=1 and stays 1; the prior read completes with the correct data.
- New rd_req asserted in the DONE cycle -> accepted immediately; second done exactly 4 cycles after the first (WAIT_CYCLES=2). With WAIT_CYCLES=0, done in the cycle after the single ACCESS cycle.
- Assert rst during ACCESS of a write to 8'h05 (old value 16'h0001) -> outputs go to 0 asynchronously, no done; reading 8'h05 later returns 16'h0001.
- With MEM_PARITY_EN: force a stored bit flip via hierarchical access -> read sets par_err=1; next clean read clears it.
